// File: rtl/axi_wr_resp_tracker_if.sv
// -----------------------------------------------------------------------------
// axi_wr_resp_tracker_if
// Bundle of the AXI write-address and write-response signals seen by the
// write-response tracker.
//   master : bus side (write master plus interconnect). Drives the AW handshake,
//            AW ID and the B channel payload, and receives bready.
//   slave  : tracker side. Snoops everything and owns m_axi_bready.
// Signals:
//   m_axi_awvalid / m_axi_awready / m_axi_awid : snooped AW handshake and ID
//   m_axi_bvalid / m_axi_bid / m_axi_bresp     : B channel from the bus
//   m_axi_bready                               : B channel ready (tracker)
// -----------------------------------------------------------------------------
interface axi_wr_resp_tracker_if #(
    parameter int ID_WIDTH = 2
);
    logic                m_axi_awvalid;
    logic                m_axi_awready;
    logic [ID_WIDTH-1:0] m_axi_awid;
    logic                m_axi_bvalid;
    logic [ID_WIDTH-1:0] m_axi_bid;
    logic [1:0]          m_axi_bresp;
    logic                m_axi_bready;

    modport master (
        output m_axi_awvalid, m_axi_awready, m_axi_awid,
        output m_axi_bvalid, m_axi_bid, m_axi_bresp,
        input  m_axi_bready
    );

    modport slave (
        input  m_axi_awvalid, m_axi_awready, m_axi_awid,
        input  m_axi_bvalid, m_axi_bid, m_axi_bresp,
        output m_axi_bready
    );
endinterface

// File: rtl/axi_wr_resp_tracker.sv
// -----------------------------------------------------------------------------
// axi_wr_resp_tracker
// Sits downstream of the AXI write master. Snoops AW handshakes, owns bready,
// and matches B responses against per-ID outstanding counters. Reports job
// completion and sticky error conditions to the engine control logic.
// Ports:
//   clk, rst            : clock (rising edge) and async active-high reset
//   bus (slave)         : AW snoop, B channel, bready
//   engine_start_pulse  : one-cycle job start (accepted in IDLE only)
//   expected_bursts     : B responses completing the job, sampled at start
//   timeout_limit       : stall limit in cycles (0 = off), sampled at start
//   resp_count          : B handshakes accepted in the current job
//   outstanding_total   : registered sum of per-ID counters (one-cycle lag)
//   wr_done_pulse       : one-cycle completion strobe
//   error_code          : sticky [0] bresp!=0 [1] B with nothing outstanding
//                         [2] timeout [3] per-ID counter overflow
//   wr_error            : OR of error_code
// -----------------------------------------------------------------------------
module axi_wr_resp_tracker #(
    parameter int ID_WIDTH      = 2,
    parameter int OUTST_WIDTH   = 8,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    axi_wr_resp_tracker_if.slave            bus,
    input  logic                            engine_start_pulse,
    input  logic [31:0]                     expected_bursts,
    input  logic [TIMEOUT_WIDTH-1:0]        timeout_limit,
    output logic [31:0]                     resp_count,
    output logic [OUTST_WIDTH+ID_WIDTH-1:0] outstanding_total,
    output logic                            wr_done_pulse,
    output logic [3:0]                      error_code,
    output logic                            wr_error
);
    localparam int NUM_IDS = 1 << ID_WIDTH;
    localparam int TOT_W   = OUTST_WIDTH + ID_WIDTH;

    localparam logic [OUTST_WIDTH-1:0]   CNT_ONE  = OUTST_WIDTH'(1);
    localparam logic [OUTST_WIDTH-1:0]   CNT_MAX  = {OUTST_WIDTH{1'b1}};
    localparam logic [TIMEOUT_WIDTH-1:0] IDLE_ONE = TIMEOUT_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] IDLE_MAX = {TIMEOUT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   state_r, state_s;
    logic [OUTST_WIDTH-1:0]   cnt_r [NUM_IDS];
    logic [OUTST_WIDTH-1:0]   cnt_s [NUM_IDS];
    logic [31:0]              expected_r;
    logic [31:0]              resp_count_r, resp_count_s;
    logic [TIMEOUT_WIDTH-1:0] timeout_limit_r;
    logic [TIMEOUT_WIDTH-1:0] idle_cnt_r, idle_cnt_s;
    logic [TOT_W-1:0]         total_r, total_s;
    logic [3:0]               error_r, error_s;
    logic                     bready_r;
    logic                     done_r;
    logic                     aw_fire_s;
    logic                     b_fire_s;
    logic                     start_ok_s;
    logic                     last_resp_s;
    logic                     timeout_hit_s;

    // Handshake qualification: AW only counts in RUN; bready_r is high only in RUN.
    always_comb begin
        aw_fire_s   = bus.m_axi_awvalid & bus.m_axi_awready & (state_r == ST_RUN);
        b_fire_s    = bus.m_axi_bvalid & bready_r;
        start_ok_s  = (state_r == ST_IDLE) & engine_start_pulse & (expected_bursts != 32'd0);
        last_resp_s = b_fire_s & ((resp_count_r + 32'd1) == expected_r);
    end

    // Stall counter: runs while responses are owed and none arrive.
    // The hit fires on the increment that lands on the limit, so the done
    // pulse appears limit+1 cycles after the last B handshake.
    always_comb begin
        idle_cnt_s    = idle_cnt_r;
        timeout_hit_s = 1'b0;
        if ((state_r != ST_RUN) || b_fire_s || (total_r == {TOT_W{1'b0}})) begin
            idle_cnt_s = {TIMEOUT_WIDTH{1'b0}};
        end else begin
            if (idle_cnt_r != IDLE_MAX) begin
                idle_cnt_s = idle_cnt_r + IDLE_ONE;
            end else begin
                idle_cnt_s = idle_cnt_r;
            end
            if ((timeout_limit_r != {TIMEOUT_WIDTH{1'b0}}) &&
                ((idle_cnt_r + IDLE_ONE) == timeout_limit_r)) begin
                timeout_hit_s = 1'b1;
            end else begin
                timeout_hit_s = 1'b0;
            end
        end
    end

    // Per-ID counter update and error detection. A same-ID AW and B in one
    // cycle cancel out and cannot raise overflow or underflow.
    always_comb begin
        error_s = error_r;
        for (int i = 0; i < NUM_IDS; i++) begin
            cnt_s[i] = cnt_r[i];
            if (aw_fire_s && (bus.m_axi_awid == ID_WIDTH'(i)) &&
                b_fire_s && (bus.m_axi_bid == ID_WIDTH'(i))) begin
                cnt_s[i] = cnt_r[i];
            end else if (aw_fire_s && (bus.m_axi_awid == ID_WIDTH'(i))) begin
                if (cnt_r[i] == CNT_MAX) begin
                    error_s[3] = 1'b1;
                end else begin
                    cnt_s[i] = cnt_r[i] + CNT_ONE;
                end
            end else if (b_fire_s && (bus.m_axi_bid == ID_WIDTH'(i))) begin
                if (cnt_r[i] == {OUTST_WIDTH{1'b0}}) begin
                    error_s[1] = 1'b1;
                end else begin
                    cnt_s[i] = cnt_r[i] - CNT_ONE;
                end
            end else begin
                cnt_s[i] = cnt_r[i];
            end
        end
        if (b_fire_s && (bus.m_axi_bresp != 2'b00)) begin
            error_s[0] = 1'b1;
        end else begin
            error_s[0] = error_s[0];
        end
        if (timeout_hit_s) begin
            error_s[2] = 1'b1;
        end else begin
            error_s[2] = error_s[2];
        end
    end

    // Response counter and sum of the current per-ID counters.
    always_comb begin
        if (b_fire_s) begin
            resp_count_s = resp_count_r + 32'd1;
        end else begin
            resp_count_s = resp_count_r;
        end
        total_s = {TOT_W{1'b0}};
        for (int i = 0; i < NUM_IDS; i++) begin
            total_s = total_s + {{ID_WIDTH{1'b0}}, cnt_r[i]};
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_resp_s || timeout_hit_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, registered outputs and job bookkeeping. An accepted start clears
    // the job state and the sum so no stale total from the prior job shows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            bready_r        <= 1'b0;
            done_r          <= 1'b0;
            expected_r      <= 32'd0;
            timeout_limit_r <= {TIMEOUT_WIDTH{1'b0}};
            idle_cnt_r      <= {TIMEOUT_WIDTH{1'b0}};
            resp_count_r    <= 32'd0;
            error_r         <= 4'd0;
            total_r         <= {TOT_W{1'b0}};
            for (int i = 0; i < NUM_IDS; i++) begin
                cnt_r[i] <= {OUTST_WIDTH{1'b0}};
            end
        end else begin
            state_r    <= state_s;
            bready_r   <= (state_s == ST_RUN);
            done_r     <= (state_s == ST_DONE);
            idle_cnt_r <= idle_cnt_s;
            if (start_ok_s) begin
                expected_r      <= expected_bursts;
                timeout_limit_r <= timeout_limit;
                resp_count_r    <= 32'd0;
                error_r         <= 4'd0;
                total_r         <= {TOT_W{1'b0}};
                for (int i = 0; i < NUM_IDS; i++) begin
                    cnt_r[i] <= {OUTST_WIDTH{1'b0}};
                end
            end else begin
                expected_r      <= expected_r;
                timeout_limit_r <= timeout_limit_r;
                resp_count_r    <= resp_count_s;
                error_r         <= error_s;
                total_r         <= total_s;
                for (int i = 0; i < NUM_IDS; i++) begin
                    cnt_r[i] <= cnt_s[i];
                end
            end
        end
    end

    assign bus.m_axi_bready  = bready_r;
    assign wr_done_pulse     = done_r;
    assign resp_count        = resp_count_r;
    assign outstanding_total = total_r;
    assign error_code        = error_r;
    assign wr_error          = |error_r;

endmodule

// File: doc/axi_wr_resp_tracker.md
# axi_wr_resp_tracker

Write-response tracker placed directly downstream of the AXI write master. It snoops the master's AW handshakes, owns `bready`, and matches B responses against per-ID outstanding counts. It reports completion, BRESP errors, responses on IDs with nothing outstanding, per-ID overflow, and response timeouts to the engine control logic. It replaces a bare burst counter with ID-aware checking for the single-engine action.

## Interface
- `ID_WIDTH`, 2, AXI ID width; sizes the per-ID counter array (2^ID_WIDTH entries).
- `OUTST_WIDTH`, 8, width of each per-ID outstanding counter.
- `TIMEOUT_WIDTH`, 16, width of the timeout limit and the idle-cycle counter.
- `clk`  in  1  sole clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `engine_start_pulse`  in  1  one-cycle start; same pulse that starts the write master.
- `expected_bursts`  in  32  number of B responses that complete the job; sampled at start.
- `timeout_limit`  in  TIMEOUT_WIDTH  stall limit in cycles; 0 disables the timeout; sampled at start.
- `m_axi_awvalid`, `m_axi_awready`  in  1 each  snooped AW handshake.
- `m_axi_awid`  in  ID_WIDTH  snooped AW ID.
- `m_axi_bvalid`  in  1  B channel valid.
- `m_axi_bid`  in  ID_WIDTH  B channel ID.
- `m_axi_bresp`  in  2  B channel response.
- `m_axi_bready`  out  1  B channel ready.
- `resp_count`  out  32  B handshakes accepted in the current job.
- `outstanding_total`  out  OUTST_WIDTH+ID_WIDTH  sum of all per-ID counters.
- `wr_done_pulse`  out  1  one-cycle job completion.
- `error_code`  out  4  sticky error bits: [0] BRESP≠0, [1] B on an ID with zero outstanding, [2] timeout, [3] per-ID counter overflow.
- `wr_error`  out  1  OR of `error_code`.

## Operation
- Definitions: `aw_fire = awvalid & awready`; `b_fire = bvalid & bready`.
- States: IDLE, RUN, DONE.
- IDLE:
  - `bready=0`.
  - Start with `expected_bursts≠0` clears all counters, `error_code`, and `resp_count`, latches the inputs, and goes to RUN.
  - Start with `expected_bursts=0` is ignored.
- RUN:
  - `bready=1`.
  - `aw_fire` increments `cnt[awid]`. At the all-ones value the counter holds and sets bit 3.
  - `b_fire` decrements `cnt[bid]` and increments `resp_count`.
  - `b_fire` with `bresp≠0` sets bit 0.
  - `b_fire` with `cnt[bid]==0` and no same-cycle `aw_fire` on the same ID sets bit 1. The counter does not decrement and `resp_count` still increments.
  - Same-cycle `aw_fire` and `b_fire` on the same ID leave the counter unchanged and set no error.
  - A start pulse in RUN is ignored.
  - A `b_fire` that brings `resp_count` to `expected_bursts` goes to DONE.
  - Timeout counter:
    - Clears on any `b_fire` and whenever `outstanding_total==0`.
    - Otherwise increments, saturating.
    - When `timeout_limit≠0` and the counter reaches `timeout_limit`, sets bit 2 and goes to DONE.
- DONE:
  - Lasts one cycle with `wr_done_pulse=1` and `bready=0`, then returns to IDLE.
  - `error_code` and `resp_count` hold until the next accepted start.
- AW handshakes outside RUN are not counted.
- The `outstanding_total` sum is registered and lags the counters by one cycle; the timeout uses the registered value.

## Timing
- Reset values:
  - `m_axi_bready=0`, `wr_done_pulse=0`.
  - `error_code=0`, `wr_error=0`.
  - `resp_count=0`, `outstanding_total=0`.
  - All per-ID counters 0; state IDLE.
  - Reset asserted mid-job forces these immediately (asynchronous). No pulse is produced, and in-flight B responses are dropped.
- Start pulse at cycle N: state is RUN and `bready=1` at N+1.
- Final `b_fire` at cycle M: `resp_count` updated and `wr_done_pulse=1` at M+1; `bready=0` at M+1; state is IDLE at M+2.
- Error bits update on the edge after the causing handshake. `wr_error` is combinational from `error_code`.
- Timeout: with the last `b_fire` at cycle T and `outstanding_total>0`, bit 2 and `wr_done_pulse` assert when the idle count reaches `timeout_limit`, i.e. at T+`timeout_limit`+1.
- Arithmetic: counters are unsigned and wrap-free. `resp_count` is 32 bits and is not incremented past `expected_bursts`, because the job ends there.

## Test plan
- Start with `expected_bursts=4` → 4 AW on IDs 0,1,2,3, then 4 OKAY B in reverse ID order → `wr_done_pulse` one cycle after the 4th B, `error_code=0`, `resp_count=4`.
- B with `bresp=2'b10` on the 2nd of 3 bursts → `error_code=4'b0001`, `wr_error=1`, done after the 3rd B; the next start clears `error_code` to 0.
- B on ID 3 with `cnt[3]=0` → bit 1 set, `resp_count` increments, `cnt[3]` stays 0; same-cycle AW ID 1 plus B ID 1 with `cnt[1]=0` → no error.
- `timeout_limit=10`, 2 AW, 1 B, then silence → bit 2 and done pulse 11 cycles after the B, `resp_count=1`.
- `OUTST_WIDTH=2`: 4 AW on ID 0 before any B → `cnt[0]` holds at 3, bit 3 set.
- Reset asserted mid-job with 3 outstanding → outputs at reset values immediately; a start with `expected_bursts=0` afterwards → stays IDLE with `bready=0`.
